lcd_grid_pic: RTL and testbench

Parametrised, pipelined pixel generator for the LCD keypad screen. Draws a ROWS x COLS grid of buttons with a cursor highlight that blinks at a frame-counted rate, and flashes a selected button for a set number of frames. Sits between the LCD timing driver, which supplies pix_x/pix_y/pix_valid, and the LCD output path. The cursor/keypad controller supplies cursor_x, cursor_y and select.

---
 rtl/lcd_grid_pic_if.sv | 24 ++
 rtl/lcd_grid_pic.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_grid_pic.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_grid_pic_if.sv
// Pixel/cursor bus between the LCD timing driver, keypad controller and the
// lcd_grid_pic pixel generator. The master drives coordinates and cursor
// state; the slave (pixel generator) returns colour and flash status.
interface lcd_grid_pic_if;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        pix_valid;
  logic [3:0]  cursor_x;
  logic [3:0]  cursor_y;
  logic        select;
  logic [23:0] pix_data;
  logic        pix_data_valid;
  logic        flash_busy;

  modport master (
    output pix_x, pix_y, pix_valid, cursor_x, cursor_y, select,
    input  pix_data, pix_data_valid, flash_busy
  );

  modport slave (
    input  pix_x, pix_y, pix_valid, cursor_x, cursor_y, select,
    output pix_data, pix_data_valid, flash_busy
  );
endinterface

// File: rtl/lcd_grid_pic.sv
// lcd_grid_pic: 2-stage pipelined keypad-screen pixel generator.
// Stage 1 does the button hit test, stage 2 picks the colour.
// Cursor highlight blinks every BLINK_FRAMES frames; a select flashes the
// chosen button RED for FLASH_FRAMES frames.
// Optional macro LCD_GRID_BORDER_EN adds a 2-pixel black frame inside each
// button (overrides GRAY/ORANGE, not RED).
module lcd_grid_pic #(
  parameter int ROWS         = 4,
  parameter int COLS         = 3,
  parameter int BTN_W        = 60,
  parameter int BTN_H        = 60,
  parameter int GAP_X        = 20,
  parameter int GAP_Y        = 20,
  parameter int ORIGIN_X     = 100,
  parameter int ORIGIN_Y     = 150,
  parameter int BANNER_H     = 100,
  parameter int BLINK_FRAMES = 30,
  parameter int FLASH_FRAMES = 10
) (
  input logic          clk_in,
  input logic          sys_rst,
  lcd_grid_pic_if.slave bus
);

  localparam logic [23:0] BLACK  = 24'h000000;
  localparam logic [23:0] RED    = 24'hFF0000;
  localparam logic [23:0] ORANGE = 24'hFFA500;
  localparam logic [23:0] GRAY   = 24'hBEBEBE;
  localparam logic [23:0] YELLOW = 24'hFFFF00;
  localparam logic [23:0] WHITE  = 24'hFFFFFF;

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [3:0]    ROWS_L     = 4'(ROWS);
  localparam logic [3:0]    COLS_L     = 4'(COLS);
  localparam logic [11:0]   BANNER_L   = 12'(BANNER_H);

  typedef enum logic {IDLE, FLASH} flash_state_t;

  logic [11:0]     x_ext, y_ext;
  logic [COLS-1:0] col_hit;
  logic [ROWS-1:0] row_hit;
  logic [3:0]      col_idx, row_idx;
  logic            in_button_c, cursor_ok, cursor_hit_c, frame_tick;

  assign x_ext = {1'b0, bus.pix_x};
  assign y_ext = {1'b0, bus.pix_y};

`ifdef LCD_GRID_BORDER_EN
  logic [COLS-1:0] col_edge;
  logic [ROWS-1:0] row_edge;
  logic            border_c, border_reg;
`endif

  // Per-column and per-row span tests; a pixel is in a button when both hit
  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      localparam logic [11:0] LEFT  = 12'(ORIGIN_X + gi * (BTN_W + GAP_X));
      localparam logic [11:0] RIGHT = 12'(ORIGIN_X + gi * (BTN_W + GAP_X) + BTN_W);
      assign col_hit[gi] = (x_ext >= LEFT) && (x_ext < RIGHT);
`ifdef LCD_GRID_BORDER_EN
      assign col_edge[gi] = (x_ext < LEFT + 12'd2) || (x_ext >= RIGHT - 12'd2);
`endif
    end
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      localparam logic [11:0] TOP = 12'(ORIGIN_Y + gi * (BTN_H + GAP_Y));
      localparam logic [11:0] BOT = 12'(ORIGIN_Y + gi * (BTN_H + GAP_Y) + BTN_H);
      assign row_hit[gi] = (y_ext >= TOP) && (y_ext < BOT);
`ifdef LCD_GRID_BORDER_EN
      assign row_edge[gi] = (y_ext < TOP + 12'd2) || (y_ext >= BOT - 12'd2);
`endif
    end
  endgenerate

  // Encode the hit column/row into an index (spans never overlap)
  always_comb begin
    col_idx = '0;
    row_idx = '0;
    for (int c = 0; c < COLS; c++) if (col_hit[c]) col_idx = 4'(c);
    for (int r = 0; r < ROWS; r++) if (row_hit[r]) row_idx = 4'(r);
  end

  assign in_button_c  = (|col_hit) && (|row_hit);
  assign cursor_ok    = (bus.cursor_x < COLS_L) && (bus.cursor_y < ROWS_L);
  assign cursor_hit_c = in_button_c && cursor_ok &&
                        (col_idx == bus.cursor_x) && (row_idx == bus.cursor_y);
`ifdef LCD_GRID_BORDER_EN
  assign border_c = in_button_c && ((|(col_hit & col_edge)) || (|(row_hit & row_edge)));
`endif

  // Frame tick fires on the first origin cycle only, even if coordinates hold
  logic origin_c, origin_prev_reg;
  assign origin_c   = bus.pix_valid && (bus.pix_x == 11'd0) && (bus.pix_y == 11'd0);
  assign frame_tick = origin_c && !origin_prev_reg;

  // Stage 1 pipeline registers plus origin edge history
  logic       in_button_reg, in_banner_reg, valid_reg, cursor_hit_reg;
  logic [3:0] btn_row_reg, btn_col_reg;
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      in_button_reg   <= 1'b0;
      in_banner_reg   <= 1'b0;
      valid_reg       <= 1'b0;
      cursor_hit_reg  <= 1'b0;
      btn_row_reg     <= '0;
      btn_col_reg     <= '0;
      origin_prev_reg <= 1'b0;
`ifdef LCD_GRID_BORDER_EN
      border_reg      <= 1'b0;
`endif
    end else begin
      in_button_reg   <= in_button_c;
      in_banner_reg   <= (y_ext < BANNER_L);
      valid_reg       <= bus.pix_valid;
      cursor_hit_reg  <= cursor_hit_c;
      btn_row_reg     <= row_idx;
      btn_col_reg     <= col_idx;
      origin_prev_reg <= origin_c;
`ifdef LCD_GRID_BORDER_EN
      border_reg      <= border_c;
`endif
    end
  end

  // Blink counter: toggle the cursor phase every BLINK_FRAMES frame ticks
  logic [BW-1:0] blink_cnt_reg;
  logic          blink_phase_reg;
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BW'(1);
      end
    end
  end

  // Flash FSM state register
  flash_state_t  state_reg, state_next;
  logic [FW-1:0] flash_cnt_reg, flash_cnt_next;
  logic [3:0]    flash_row_reg, flash_row_next, flash_col_reg, flash_col_next;
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      state_reg     <= IDLE;
      flash_cnt_reg <= '0;
      flash_row_reg <= '0;
      flash_col_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flash_cnt_reg <= flash_cnt_next;
      flash_row_reg <= flash_row_next;
      flash_col_reg <= flash_col_next;
    end
  end

  // Flash FSM next state: a valid select (re)latches and wins over completion
  always_comb begin
    state_next     = state_reg;
    flash_cnt_next = flash_cnt_reg;
    flash_row_next = flash_row_reg;
    flash_col_next = flash_col_reg;
    if (bus.select && cursor_ok) begin
      state_next     = FLASH;
      flash_cnt_next = '0;
      flash_row_next = bus.cursor_y;
      flash_col_next = bus.cursor_x;
    end else if (state_reg == FLASH && frame_tick) begin
      if (flash_cnt_reg == FLASH_LAST) begin
        state_next     = IDLE;
        flash_cnt_next = '0;
      end else begin
        flash_cnt_next = flash_cnt_reg + FW'(1);
      end
    end
  end

  assign bus.flash_busy = (state_reg == FLASH);

  // Stage 2 colour selection in priority order
  logic        flash_hit;
  logic [23:0] colour_next;
  assign flash_hit = (state_reg == FLASH) && in_button_reg &&
                     (btn_row_reg == flash_row_reg) && (btn_col_reg == flash_col_reg);
  always_comb begin
    colour_next = WHITE;
    if (!valid_reg)                            colour_next = BLACK;
    else if (flash_hit)                        colour_next = RED;
`ifdef LCD_GRID_BORDER_EN
    else if (border_reg)                       colour_next = BLACK;
`endif
    else if (cursor_hit_reg && blink_phase_reg) colour_next = ORANGE;
    else if (in_button_reg)                    colour_next = GRAY;
    else if (in_banner_reg)                    colour_next = YELLOW;
  end

  // Stage 2 output registers
  logic [23:0] pix_data_reg;
  logic        pix_data_valid_reg;
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      pix_data_reg       <= BLACK;
      pix_data_valid_reg <= 1'b0;
    end else begin
      pix_data_reg       <= colour_next;
      pix_data_valid_reg <= valid_reg;
    end
  end

  assign bus.pix_data       = pix_data_reg;
  assign bus.pix_data_valid = pix_data_valid_reg;

endmodule

// File: tb/tb_lcd_grid_pic.sv
// Testbench for lcd_grid_pic: table-driven pixel vectors plus hand-written
// blink/flash/reset sequences, all checked through an expected-result queue.
module tb_lcd_grid_pic;

  localparam logic [23:0] BLACK  = 24'h000000;
  localparam logic [23:0] RED    = 24'hFF0000;
  localparam logic [23:0] ORANGE = 24'hFFA500;
  localparam logic [23:0] GRAY   = 24'hBEBEBE;
  localparam logic [23:0] YELLOW = 24'hFFFF00;
  localparam logic [23:0] WHITE  = 24'hFFFFFF;

  logic clk_in  = 1'b0;
  logic sys_rst = 1'b1;
  lcd_grid_pic_if bus ();

  lcd_grid_pic dut (
    .clk_in (clk_in),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [23:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [3:0]  cx;
    logic [3:0]  cy;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[17];

  // reference blink model
  int   bcnt   = 0;
  logic bphase = 1'b1;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Output monitor: pop expected colour and due cycle for every valid output
  always @(negedge clk_in) begin
    if (mon_en) begin
      checks++;
      if (bus.pix_data_valid) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pix_unexpected got valid pix_data %h want no output (cycle %0d)",
                   bus.pix_data, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (bus.pix_data !== mon_e.data || cyc != mon_e.due) begin
            errors++;
            $display("FAIL pix_data got %h at cycle %0d want %h at cycle %0d",
                     bus.pix_data, cyc, mon_e.data, mon_e.due);
          end else begin
            $display("tx cycle %0d pix_data %h ok", cyc, bus.pix_data);
          end
        end
      end else if (bus.pix_data !== BLACK) begin
        errors++;
        $display("FAIL idle_black got %h want %h (cycle %0d)", bus.pix_data, BLACK, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic drive_pix(input logic [10:0] x, input logic [10:0] y, input logic [23:0] exp);
    bus.pix_x     = x;
    bus.pix_y     = y;
    bus.pix_valid = 1'b1;
    sb.push_back('{exp, cyc + 2});
    step();
    bus.pix_valid = 1'b0;
  endtask

  // One frame tick: hold origin for `hold` cycles, then one idle cycle
  task automatic tick(input int hold, input logic sel);
    bus.select = sel;
    for (int h = 0; h < hold; h++) begin
      drive_pix(11'd0, 11'd0, YELLOW);
      bus.select = 1'b0;
    end
    step();
    if (bcnt == 29) begin
      bcnt   = 0;
      bphase = ~bphase;
    end else begin
      bcnt++;
    end
  endtask

  function automatic logic [23:0] cur_col();
    return bphase ? ORANGE : GRAY;
  endfunction

  task automatic pulse_select(input logic [3:0] cx, input logic [3:0] cy);
    bus.cursor_x = cx;
    bus.cursor_y = cy;
    bus.select   = 1'b1;
    step();
    bus.select   = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{11'd100, 11'd150, 4'd0, 4'd0, ORANGE};
    vecs[1]  = '{11'd160, 11'd150, 4'd0, 4'd0, WHITE};
    vecs[2]  = '{11'd5,   11'd50,  4'd0, 4'd0, YELLOW};
    vecs[3]  = '{11'd260, 11'd230, 4'd2, 4'd1, ORANGE};
    vecs[4]  = '{11'd259, 11'd230, 4'd2, 4'd1, WHITE};
    vecs[5]  = '{11'd100, 11'd150, 4'd3, 4'd0, GRAY};
    vecs[6]  = '{11'd159, 11'd209, 4'd0, 4'd0, ORANGE};
    vecs[7]  = '{11'd180, 11'd150, 4'd0, 4'd0, GRAY};
    vecs[8]  = '{11'd319, 11'd449, 4'd0, 4'd0, GRAY};
    vecs[9]  = '{11'd100, 11'd150, 4'd0, 4'd4, GRAY};
    vecs[10] = '{11'd180, 11'd390, 4'd1, 4'd3, ORANGE};
    vecs[11] = '{11'd320, 11'd150, 4'd0, 4'd0, WHITE};
    vecs[12] = '{11'd100, 11'd450, 4'd0, 4'd0, WHITE};
    vecs[13] = '{11'd50,  11'd99,  4'd0, 4'd0, YELLOW};
    vecs[14] = '{11'd50,  11'd100, 4'd0, 4'd0, WHITE};
    vecs[15] = '{11'd100, 11'd149, 4'd0, 4'd0, WHITE};
    vecs[16] = '{11'd239, 11'd289, 4'd1, 4'd1, ORANGE};

    bus.pix_x     = 11'd100;
    bus.pix_y     = 11'd150;
    bus.pix_valid = 1'b1;
    bus.cursor_x  = 4'd0;
    bus.cursor_y  = 4'd0;
    bus.select    = 1'b0;

    // Reset held 3 cycles with valid pixels present
    sys_rst = 1'b1;
    step();
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_bit("rst_valid", bus.pix_data_valid, 1'b0);
      checks++;
      if (bus.pix_data !== BLACK) begin
        errors++;
        $display("FAIL rst_data got %h want %h", bus.pix_data, BLACK);
      end
      check_bit("rst_busy", bus.flash_busy, 1'b0);
      step();
    end
    sys_rst       = 1'b0;
    bus.pix_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_bit("post_rst_valid", bus.pix_data_valid, 1'b0);
    end

    // Table of static pixels
    for (int i = 0; i < 17; i++) begin
      bus.cursor_x = vecs[i].cx;
      bus.cursor_y = vecs[i].cy;
      drive_pix(vecs[i].x, vecs[i].y, vecs[i].exp);
    end

    // Blink: 60 ticks with varying origin hold length
    bus.cursor_x = 4'd0;
    bus.cursor_y = 4'd0;
    for (int t = 1; t <= 60; t++) begin
      tick(1 + (t % 3), 1'b0);
      drive_pix(11'd120, 11'd170, cur_col());
    end

    // Flash of (1,1) for 10 ticks
    pulse_select(4'd1, 4'd1);
    check_bit("flash_busy_start", bus.flash_busy, 1'b1);
    drive_pix(11'd200, 11'd250, RED);
    for (int t = 1; t <= 10; t++) begin
      tick(1, 1'b0);
      drive_pix(11'd200, 11'd250, (t < 10) ? RED : cur_col());
      check_bit($sformatf("flash_busy_t%0d", t), bus.flash_busy, (t < 10));
    end

    // Select with cursor out of range is ignored
    pulse_select(4'd0, 4'd4);
    check_bit("oob_select_busy", bus.flash_busy, 1'b0);
    pulse_select(4'd3, 4'd0);
    check_bit("oob_select_busy2", bus.flash_busy, 1'b0);

    // Re-select mid-flash moves the flash to (2,3)
    pulse_select(4'd0, 4'd0);
    for (int t = 1; t <= 4; t++) begin
      tick(1, 1'b0);
      drive_pix(11'd120, 11'd170, RED);
    end
    bus.cursor_x = 4'd2;
    bus.cursor_y = 4'd3;
    tick(1, 1'b1);
    drive_pix(11'd120, 11'd170, GRAY);
    drive_pix(11'd280, 11'd410, RED);
    for (int k = 6; k <= 15; k++) begin
      tick(1, 1'b0);
      drive_pix(11'd280, 11'd410, (k < 15) ? RED : cur_col());
      drive_pix(11'd120, 11'd170, GRAY);
      check_bit($sformatf("reflash_busy_k%0d", k), bus.flash_busy, (k < 15));
    end

    // Select on the completing tick wins: flash restarts on (1,0)
    pulse_select(4'd0, 4'd0);
    for (int t = 1; t <= 9; t++) tick(1, 1'b0);
    bus.cursor_x = 4'd1;
    bus.cursor_y = 4'd0;
    tick(1, 1'b1);
    check_bit("sel_priority_busy", bus.flash_busy, 1'b1);
    drive_pix(11'd190, 11'd160, RED);
    drive_pix(11'd120, 11'd170, GRAY);

    // Drain, then reset mid-frame: in-flight pixels vanish, flash aborts
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    bus.pix_x     = 11'd200;
    bus.pix_y     = 11'd250;
    bus.pix_valid = 1'b1;
    step();
    sys_rst = 1'b1;
    step();
    sys_rst       = 1'b0;
    bus.pix_valid = 1'b0;
    bcnt   = 0;
    bphase = 1'b1;
    check_bit("rst_abort_busy", bus.flash_busy, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_bit("mid_rst_valid", bus.pix_data_valid, 1'b0);
    end
    bus.cursor_x = 4'd0;
    bus.cursor_y = 4'd0;
    drive_pix(11'd120, 11'd170, ORANGE);
    drive_pix(11'd200, 11'd250, GRAY);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
